// File: rtl/aes_round_ctrl.sv
// Round sequencer for the iterative AES-128 core: INIT, NROUNDS-1 full rounds, FINAL, then DONE.
// Optional AES_CTRL_ABORT_EN adds an abort port; load raised mid-run then cancels the encryption.
module aes_round_ctrl #(
  parameter int unsigned NROUNDS          = 10,
  parameter int unsigned CYCLES_PER_ROUND = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  output logic [3:0] round,
  output logic [7:0] rcon,
  output logic       init_round,
  output logic       final_round,
  output logic       state_en,
  output logic       key_en,
  output logic       busy,
`ifdef AES_CTRL_ABORT_EN
  output logic       abort,
`endif
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic       load_q, load_d;
  logic [3:0] round_q, round_d;
  logic [7:0] rcon_q, rcon_d;
  logic [2:0] cyc_q, cyc_d;
  logic       abort_q, abort_d;

  logic start, cyc_last, running;

  assign start    = load_q & ~load;
  assign cyc_last = (cyc_q == 3'(CYCLES_PER_ROUND - 1));
  assign running  = (state_q == S_INIT) || (state_q == S_ROUND) || (state_q == S_FINAL);
  assign load_d   = load;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      load_q  <= 1'b0;
      round_q <= 4'd0;
      rcon_q  <= 8'h01;
      cyc_q   <= 3'd0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
      cyc_q   <= cyc_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_INIT;
      S_INIT:  state_d = S_ROUND;
      S_ROUND: if (cyc_last && (round_q + 4'd1 == 4'(NROUNDS))) state_d = S_FINAL;
      S_FINAL: if (cyc_last) state_d = S_DONE;
      S_DONE: begin
        if (load)       state_d = S_IDLE;
        else if (start) state_d = S_INIT;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef AES_CTRL_ABORT_EN
    if (running && load) state_d = S_IDLE;
`endif
  end

  // Counters: rcon advances with the round index; FINAL and DONE leave it at Rcon[NROUNDS].
  always_comb begin
    round_d = round_q;
    rcon_d  = rcon_q;
    cyc_d   = cyc_q;
    abort_d = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start || load) begin
          round_d = 4'd0;
          rcon_d  = 8'h01;
          cyc_d   = 3'd0;
        end
      end
      S_INIT: begin
        round_d = 4'd1;
        cyc_d   = 3'd0;
      end
      S_ROUND: begin
        if (cyc_last) begin
          round_d = round_q + 4'd1;
          rcon_d  = xtime(rcon_q);
          cyc_d   = 3'd0;
        end else begin
          cyc_d = cyc_q + 3'd1;
        end
      end
      S_FINAL: cyc_d = cyc_last ? 3'd0 : cyc_q + 3'd1;
      default: ;
    endcase
`ifdef AES_CTRL_ABORT_EN
    if (running && load) begin
      round_d = 4'd0;
      rcon_d  = 8'h01;
      cyc_d   = 3'd0;
      abort_d = 1'b1;
    end
`endif
  end

  always_comb begin
    round       = round_q;
    rcon        = rcon_q;
    init_round  = (state_q == S_INIT);
    final_round = (state_q == S_FINAL);
    key_en      = ((state_q == S_ROUND) || (state_q == S_FINAL)) && cyc_last;
    state_en    = (state_q == S_INIT) || key_en;
    busy        = running;
    done        = (state_q == S_DONE);
`ifdef AES_CTRL_ABORT_EN
    abort       = abort_q;
`endif
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench: default instance (a) and a CYCLES_PER_ROUND=3 instance (b) on a shared clock/reset.
module tb_aes_round_ctrl;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       load_a = 1'b0, load_b = 1'b0;
  logic [3:0] round_a, round_b;
  logic [7:0] rcon_a, rcon_b;
  logic       init_a, final_a, se_a, ke_a, busy_a, done_a;
  logic       init_b, final_b, se_b, ke_b, busy_b, done_b;
`ifdef AES_CTRL_ABORT_EN
  logic       abort_a, abort_b;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] rc [0:10] = '{8'h01, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                            8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  aes_round_ctrl dut_a (
    .clk(clk), .reset_n(reset_n), .load(load_a), .round(round_a), .rcon(rcon_a),
    .init_round(init_a), .final_round(final_a), .state_en(se_a), .key_en(ke_a),
    .busy(busy_a),
`ifdef AES_CTRL_ABORT_EN
    .abort(abort_a),
`endif
    .done(done_a)
  );

  aes_round_ctrl #(.NROUNDS(10), .CYCLES_PER_ROUND(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .load(load_b), .round(round_b), .rcon(rcon_b),
    .init_round(init_b), .final_round(final_b), .state_en(se_b), .key_en(ke_b),
    .busy(busy_b),
`ifdef AES_CTRL_ABORT_EN
    .abort(abort_b),
`endif
    .done(done_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {init_round, final_round, state_en, key_en, busy, done, round, rcon}
  function automatic logic [17:0] st_a();
    return {init_a, final_a, se_a, ke_a, busy_a, done_a, round_a, rcon_a};
  endfunction

  function automatic logic [17:0] st_b();
    return {init_b, final_b, se_b, ke_b, busy_b, done_b, round_b, rcon_b};
  endfunction

  // First step lands on the start edge; load_a is raised after round inj and dropped one round later.
  task automatic run_a(input string tag, input int inj);
    int se, ke;
    logic [5:0] fl;
    se = 0;
    ke = 0;
    step();
    chk({tag, "_init"}, st_a(), {6'b101010, 4'd0, 8'h01});
    se += int'(se_a);
    ke += int'(ke_a);
    for (int r = 1; r <= 10; r++) begin
      step();
      fl = (r == 10) ? 6'b011110 : 6'b001110;
      chk($sformatf("%s_r%0d", tag, r), st_a(), {fl, 4'(r), rc[r]});
      se += int'(se_a);
      ke += int'(ke_a);
      if (inj != 0 && r == inj) load_a = 1'b1;
      if (inj != 0 && r == inj + 1) load_a = 1'b0;
    end
    step();
    chk({tag, "_done"}, st_a(), {6'b000001, 4'd10, 8'h36});
    chk({tag, "_se_cnt"}, se, 11);
    chk({tag, "_ke_cnt"}, ke, 10);
  endtask

  initial begin
    int bad;
    repeat (3) step();
    chk("rst_a", st_a(), {6'b0, 4'd0, 8'h01});
    chk("rst_b", st_b(), {6'b0, 4'd0, 8'h01});

    reset_n = 1'b1;
    bad = 0;
    repeat (20) begin
      step();
      if (st_a() != {6'b0, 4'd0, 8'h01} || st_b() != {6'b0, 4'd0, 8'h01}) bad++;
    end
    chk("idle_quiet", bad, 0);

    load_a = 1'b1;
    bad = 0;
    repeat (256) begin
      step();
      if (st_a() != {6'b0, 4'd0, 8'h01}) bad++;
    end
    chk("load_high_idle", bad, 0);
    load_a = 1'b0;
    run_a("enc1", 0);

    bad = 0;
    repeat (50) begin
      step();
      if (st_a() != {6'b000001, 4'd10, 8'h36}) bad++;
    end
    chk("done_hold", bad, 0);

    load_a = 1'b1;
    step();
    chk("done_fall", st_a(), {6'b0, 4'd0, 8'h01});
    load_a = 1'b0;
    run_a("enc2", 0);

    load_a = 1'b1;
    step();
    load_a = 1'b0;
`ifdef AES_CTRL_ABORT_EN
    step();
    repeat (4) step();
    chk("abort_r4", st_a(), {6'b001110, 4'd4, 8'h08});
    load_a = 1'b1;
    step();
    chk("abort_cyc", {abort_a, st_a()}, {1'b1, 6'b0, 4'd0, 8'h01});
    load_a = 1'b0;
    run_a("post_abort", 0);
    chk("abort_clr", abort_a, 1'b0);
`else
    run_a("midload", 4);
`endif

    load_a = 1'b1;
    step();
    load_a = 1'b0;
    step();
    repeat (5) step();
    chk("pre_rst_r5", st_a(), {6'b001110, 4'd5, 8'h10});
    reset_n = 1'b0;
    step();
    chk("midrst", st_a(), {6'b0, 4'd0, 8'h01});
    reset_n = 1'b1;
    bad = 0;
    repeat (5) begin
      step();
      if (st_a() != {6'b0, 4'd0, 8'h01}) bad++;
    end
    chk("midrst_quiet", bad, 0);
    load_a = 1'b1;
    step();
    load_a = 1'b0;
    run_a("post_rst", 0);

    // CYCLES_PER_ROUND=3: strobes on every third cycle, done 31 edges after start
    load_b = 1'b1;
    step();
    load_b = 1'b0;
    step();
    chk("b_init", st_b(), {6'b101010, 4'd0, 8'h01});
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < 3; c++) begin
        logic [5:0] fl;
        step();
        fl = {1'b0, (r == 10), (c == 2), (c == 2), 2'b10};
        chk($sformatf("b_r%0d_c%0d", r, c), st_b(), {fl, 4'(r), rc[r]});
      end
    end
    step();
    chk("b_done", st_b(), {6'b000001, 4'd10, 8'h36});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
